// File: rtl/stack_sequencer_pkg.sv
// Shared types for the stack transfer sequencer: mask bit positions,
// FSM states and the STACK_* mask constants.
package stack_sequencer_pkg;

    typedef enum logic [3:0] {
        IDX_AW          = 4'd0,
        IDX_CW          = 4'd1,
        IDX_DW          = 4'd2,
        IDX_BW          = 4'd3,
        IDX_SP          = 4'd4,
        IDX_BP_SKIP_SP  = 4'd5,
        IDX_BP          = 4'd6,
        IDX_IX          = 4'd7,
        IDX_IY          = 4'd8,
        IDX_DS1         = 4'd9,
        IDX_PSW         = 4'd10,
        IDX_PS          = 4'd11,
        IDX_SS          = 4'd12,
        IDX_DS0         = 4'd13,
        IDX_PC          = 4'd14,
        IDX_OPERAND     = 4'd15
    } stack_index_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_BUS,
        ST_FINISH
    } stack_state_e;

    localparam logic [15:0] STACK_AW         = 16'h0001;
    localparam logic [15:0] STACK_CW         = 16'h0002;
    localparam logic [15:0] STACK_DW         = 16'h0004;
    localparam logic [15:0] STACK_BW         = 16'h0008;
    localparam logic [15:0] STACK_SP         = 16'h0010;
    localparam logic [15:0] STACK_BP_SKIP_SP = 16'h0020;
    localparam logic [15:0] STACK_BP         = 16'h0040;
    localparam logic [15:0] STACK_IX         = 16'h0080;
    localparam logic [15:0] STACK_IY         = 16'h0100;
    localparam logic [15:0] STACK_DS1        = 16'h0200;
    localparam logic [15:0] STACK_PSW        = 16'h0400;
    localparam logic [15:0] STACK_PS         = 16'h0800;
    localparam logic [15:0] STACK_SS         = 16'h1000;
    localparam logic [15:0] STACK_DS0        = 16'h2000;
    localparam logic [15:0] STACK_PC         = 16'h4000;
    localparam logic [15:0] STACK_OPERAND    = 16'h8000;

    localparam logic [15:0] SP_STEP = 16'd2;

endpackage

// File: rtl/stack_sequencer_pick.sv
// Bidirectional 16-bit priority encoder: lowest set bit for push,
// highest set bit for pop.
module stack_pick
    import stack_sequencer_pkg::*;
(
    input  logic [15:0]  i_rem,
    input  logic         i_dir_pop,
    output stack_index_e o_index,
    output logic         o_any
);

    assign o_any = |i_rem;

    always_comb begin
        o_index = IDX_AW;
        if (i_dir_pop) begin
            for (int i = 0; i < 16; i++) begin
                if (i_rem[i]) o_index = stack_index_e'(4'(i));
            end
        end else begin
            for (int i = 15; i >= 0; i--) begin
                if (i_rem[i]) o_index = stack_index_e'(4'(i));
            end
        end
    end

endmodule

// File: rtl/stack_sequencer.sv
// Multi-word stack transfer sequencer: one bus cycle per set mask bit,
// SP tracked locally and written back once at completion.
module stack_sequencer
    import stack_sequencer_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_start,
    input  logic        i_dir_pop,
    input  logic [15:0] i_mask,
    input  logic [15:0] i_sp_in,
    input  logic [15:0] i_operand_in,
    output logic [3:0]  o_reg_sel,
    input  logic [15:0] i_reg_rdata,
    output logic        o_reg_we,
    output logic [15:0] o_reg_wdata,
    output logic        o_mem_req,
    output logic        o_mem_write,
    output logic [15:0] o_mem_addr,
    output logic [15:0] o_mem_wdata,
    input  logic [15:0] i_mem_rdata,
    input  logic        i_mem_ack,
    output logic [15:0] o_sp_out,
    output logic        o_sp_we,
    output logic        o_busy,
    output logic        o_done
);

    stack_state_e r_state;
    logic [15:0]  r_rem;
    logic         r_dir_pop;
    logic [15:0]  r_sp;
    logic [15:0]  r_sp_start;
    logic [15:0]  r_operand;
    stack_index_e r_reg_sel;
    logic         r_reg_we;
    logic [15:0]  r_reg_wdata;
    logic         r_mem_req;
    logic         r_mem_write;
    logic [15:0]  r_mem_addr;
    logic [15:0]  r_mem_wdata;
    logic [15:0]  r_sp_out;
    logic         r_sp_we;
    logic         r_busy;
    logic         r_done;

    stack_index_e w_index;
    logic         w_any;
    logic [15:0]  w_sp_dec;
    logic [15:0]  w_sp_inc;
    logic [15:0]  w_push_data;

    stack_pick u_pick (
        .i_rem     (r_rem),
        .i_dir_pop (r_dir_pop),
        .o_index   (w_index),
        .o_any     (w_any)
    );

    assign w_sp_dec = r_sp - SP_STEP;
    assign w_sp_inc = r_sp + SP_STEP;

    always_comb begin
        w_push_data = i_reg_rdata;
        if (w_index == IDX_SP) begin
            w_push_data = r_sp_start;
        end else if (w_index == IDX_OPERAND) begin
            w_push_data = r_operand;
        end
    end

    // Push scans present the candidate so the register file can return
    // its value in time; pops keep the transferred index for reg_we.
    assign o_reg_sel   = (r_state == ST_SCAN && !r_dir_pop) ? w_index : r_reg_sel;
    assign o_reg_we    = r_reg_we;
    assign o_reg_wdata = r_reg_wdata;
    assign o_mem_req   = r_mem_req;
    assign o_mem_write = r_mem_write;
    assign o_mem_addr  = r_mem_addr;
    assign o_mem_wdata = r_mem_wdata;
    assign o_sp_out    = r_sp_out;
    assign o_sp_we     = r_sp_we;
    assign o_busy      = r_busy;
    assign o_done      = r_done;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state     <= ST_IDLE;
            r_rem       <= '0;
            r_dir_pop   <= 1'b0;
            r_sp        <= '0;
            r_sp_start  <= '0;
            r_operand   <= '0;
            r_reg_sel   <= IDX_AW;
            r_reg_we    <= 1'b0;
            r_reg_wdata <= '0;
            r_mem_req   <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_sp_out    <= '0;
            r_sp_we     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_reg_we <= 1'b0;
            r_sp_we  <= 1'b0;
            r_done   <= 1'b0;
            unique case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_rem      <= i_mask;
                        r_dir_pop  <= i_dir_pop;
                        r_sp       <= i_sp_in;
                        r_sp_start <= i_sp_in;
                        r_operand  <= i_operand_in;
                        r_busy     <= 1'b1;
                        r_state    <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (!w_any) begin
                        r_sp_out <= r_sp;
                        r_sp_we  <= 1'b1;
                        r_done   <= 1'b1;
                        r_state  <= ST_FINISH;
                    end else if (w_index == IDX_BP_SKIP_SP) begin
                        r_sp           <= r_dir_pop ? w_sp_inc : w_sp_dec;
                        r_rem[w_index] <= 1'b0;
                    end else begin
                        r_reg_sel   <= w_index;
                        r_mem_req   <= 1'b1;
                        r_mem_write <= ~r_dir_pop;
                        r_mem_addr  <= r_dir_pop ? r_sp : w_sp_dec;
                        r_mem_wdata <= w_push_data;
                        r_state     <= ST_BUS;
                    end
                end
                ST_BUS: begin
                    if (i_mem_ack) begin
                        r_mem_req        <= 1'b0;
                        r_sp             <= r_dir_pop ? w_sp_inc : w_sp_dec;
                        r_rem[r_reg_sel] <= 1'b0;
                        // A popped SP word is dropped; SP keeps its own count.
                        if (r_dir_pop && r_reg_sel != IDX_SP) begin
                            r_reg_we    <= 1'b1;
                            r_reg_wdata <= i_mem_rdata;
                        end
                        r_state <= ST_SCAN;
                    end
                end
                ST_FINISH: begin
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_stack_sequencer.sv
// Scoreboard bench for stack_sequencer with a sequential reference model.
module tb_stack_sequencer;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic        i_start = 1'b0;
    logic        i_dir_pop = 1'b0;
    logic [15:0] i_mask = '0;
    logic [15:0] i_sp_in = '0;
    logic [15:0] i_operand_in = '0;
    logic [3:0]  o_reg_sel;
    logic [15:0] i_reg_rdata;
    logic        o_reg_we;
    logic [15:0] o_reg_wdata;
    logic        o_mem_req;
    logic        o_mem_write;
    logic [15:0] o_mem_addr;
    logic [15:0] o_mem_wdata;
    logic [15:0] i_mem_rdata = '0;
    logic        i_mem_ack = 1'b0;
    logic [15:0] o_sp_out;
    logic        o_sp_we;
    logic        o_busy;
    logic        o_done;

    stack_sequencer dut (
        .i_clk        (i_clk),
        .i_reset      (i_reset),
        .i_start      (i_start),
        .i_dir_pop    (i_dir_pop),
        .i_mask       (i_mask),
        .i_sp_in      (i_sp_in),
        .i_operand_in (i_operand_in),
        .o_reg_sel    (o_reg_sel),
        .i_reg_rdata  (i_reg_rdata),
        .o_reg_we     (o_reg_we),
        .o_reg_wdata  (o_reg_wdata),
        .o_mem_req    (o_mem_req),
        .o_mem_write  (o_mem_write),
        .o_mem_addr   (o_mem_addr),
        .o_mem_wdata  (o_mem_wdata),
        .i_mem_rdata  (i_mem_rdata),
        .i_mem_ack    (i_mem_ack),
        .o_sp_out     (o_sp_out),
        .o_sp_we      (o_sp_we),
        .o_busy       (o_busy),
        .o_done       (o_done)
    );

    always #5 i_clk = ~i_clk;

    typedef struct packed {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] data;
    } bus_t;

    typedef struct packed {
        logic [3:0]  sel;
        logic [15:0] data;
    } rw_t;

    bus_t        exp_bus[$];
    rw_t         exp_rw[$];
    logic [15:0] exp_sp[$];

    logic [15:0] regs [16];
    logic [15:0] mem [65536];

    int n_checks = 0;
    int n_err = 0;

    bit hold_ack = 1'b0;
    bit noise = 1'b0;
    int fixed_dly = 0;
    int dly_max = 0;

    assign i_reg_rdata = regs[o_reg_sel];

    task automatic chk(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: walk the mask in transfer order with plain SP arithmetic.
    task automatic model(input logic dir, input logic [15:0] mask,
                         input logic [15:0] sp, input logic [15:0] op);
        logic [15:0] s;
        logic [15:0] d;
        int b;
        s = sp;
        for (int k = 0; k < 16; k++) begin
            b = dir ? 15 - k : k;
            if (mask[b]) begin
                if (b == 5) begin
                    s = dir ? s + 16'd2 : s - 16'd2;
                end else if (!dir) begin
                    s = s - 16'd2;
                    d = (b == 4) ? sp : (b == 15) ? op : regs[b];
                    exp_bus.push_back('{1'b1, s, d});
                end else begin
                    exp_bus.push_back('{1'b0, s, 16'h0000});
                    if (b != 4) exp_rw.push_back('{4'(b), mem[s]});
                    s = s + 16'd2;
                end
            end
        end
        exp_sp.push_back(s);
    endtask

    // Bus responder: memory model with programmable ack delay.
    int cnt = -1;
    always @(posedge i_clk) begin
        #1;
        if (i_reset || hold_ack || !o_mem_req) begin
            cnt = -1;
            i_mem_ack = (noise && !o_mem_req) ? ($urandom_range(0, 3) == 0) : 1'b0;
            i_mem_rdata = 16'($urandom);
        end else if (i_mem_ack) begin
            i_mem_ack = 1'b0;
        end else begin
            if (cnt < 0) cnt = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(0, dly_max));
            if (cnt == 0) begin
                i_mem_ack = 1'b1;
                i_mem_rdata = mem[o_mem_addr];
                if (o_mem_write) mem[o_mem_addr] = o_mem_wdata;
                cnt = -1;
            end else begin
                cnt--;
            end
        end
    end

    // Monitor: pops expectations whenever the DUT presents a result.
    bit pend = 1'b0;
    logic [32:0] held;
    bus_t eb;
    rw_t er;
    logic [15:0] es;
    always @(negedge i_clk) begin
        if (i_reset) begin
            pend = 1'b0;
        end else begin
            if (o_mem_req && pend)
                chk("req_hold", {o_mem_write, o_mem_addr, o_mem_wdata}, held);
            pend = o_mem_req && !i_mem_ack;
            held = {o_mem_write, o_mem_addr, o_mem_wdata};
            if (o_mem_req && i_mem_ack) begin
                if (exp_bus.size() == 0) begin
                    chk("bus_extra", {o_mem_write, o_mem_addr}, 0);
                end else begin
                    eb = exp_bus.pop_front();
                    chk("bus_write", o_mem_write, eb.wr);
                    chk("bus_addr", o_mem_addr, eb.addr);
                    if (eb.wr) chk("bus_wdata", o_mem_wdata, eb.data);
                end
            end
            if (o_reg_we) begin
                if (exp_rw.size() == 0) begin
                    chk("reg_we_extra", {o_reg_sel, o_reg_wdata}, 0);
                end else begin
                    er = exp_rw.pop_front();
                    chk("reg_sel", o_reg_sel, er.sel);
                    chk("reg_wdata", o_reg_wdata, er.data);
                end
            end
            if (o_sp_we && !o_done) chk("sp_we_alone", o_sp_we, 0);
            if (o_done) begin
                if (exp_sp.size() == 0) begin
                    chk("done_extra", o_done, 0);
                end else begin
                    es = exp_sp.pop_front();
                    chk("sp_we", o_sp_we, 1);
                    chk("sp_out", o_sp_out, es);
                end
            end
        end
    end

    task automatic run_seq(input logic dir, input logic [15:0] mask,
                           input logic [15:0] sp, input logic [15:0] op, input bit poke);
        int lat;
        int nb;
        int ns;
        bit seen;
        bit poked;
        nb = 0;
        ns = 0;
        for (int b = 0; b < 16; b++) begin
            if (mask[b]) begin
                if (b == 5) ns++;
                else nb++;
            end
        end
        model(dir, mask, sp, op);
        i_dir_pop = dir;
        i_mask = mask;
        i_sp_in = sp;
        i_operand_in = op;
        i_start = 1'b1;
        lat = 0;
        seen = 1'b0;
        poked = 1'b0;
        for (int c = 0; c < 400 && !seen; c++) begin
            @(posedge i_clk);
            #1;
            lat++;
            i_start = 1'b0;
            if (poke && !poked && o_mem_req) begin
                i_start = 1'b1;
                i_mask = 16'h00FF;
                i_dir_pop = ~dir;
                i_sp_in = 16'h5555;
                poked = 1'b1;
            end
            @(negedge i_clk);
            if (lat == 1) chk("busy_rise", o_busy, 1);
            seen = o_done;
        end
        if (!seen) chk("done_timeout", 0, 1);
        else if (fixed_dly >= 0) chk("latency", lat, 2 + ns + (fixed_dly + 2) * nb);
        @(posedge i_clk);
        #1;
        @(negedge i_clk);
        chk("busy_fall", o_busy, 0);
        chk("queues_empty", exp_bus.size() + exp_rw.size() + exp_sp.size(), 0);
        if (exp_bus.size() + exp_rw.size() + exp_sp.size() != 0) begin
            exp_bus.delete();
            exp_rw.delete();
            exp_sp.delete();
        end
    endtask

    task automatic rand_regs();
        for (int r = 0; r < 16; r++) regs[r] = 16'($urandom);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit bad;
        for (int a = 0; a < 65536; a++) mem[a] = 16'($urandom);
        rand_regs();
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        chk("reset_outputs", {o_reg_sel, o_reg_we, o_reg_wdata, o_mem_req, o_mem_write,
            o_mem_addr, o_mem_wdata, o_sp_out, o_sp_we, o_busy, o_done}, 0);
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;

        // PUSH R: AW..IY, SP word carries the original SP.
        for (int r = 0; r < 16; r++) regs[r] = 16'(r);
        regs[0] = 16'd1; regs[1] = 16'd2; regs[2] = 16'd3; regs[3] = 16'd4;
        regs[6] = 16'd6; regs[7] = 16'd7; regs[8] = 16'd8;
        fixed_dly = 0;
        run_seq(1'b0, 16'h01DF, 16'h1000, 16'h0000, 1'b0);
        chk("pushr_sp", o_sp_out, 16'h0FF0);

        // POP R: everything except SP, with the SP skip.
        run_seq(1'b1, 16'h01EF, 16'h0FF0, 16'h0000, 1'b0);
        chk("popr_sp", o_sp_out, 16'h1000);

        // Interrupt entry wrapping below zero.
        rand_regs();
        run_seq(1'b0, 16'h4C00, 16'h0000, 16'h0000, 1'b0);
        chk("irq_sp", o_sp_out, 16'hFFFA);

        // Empty mask.
        run_seq(1'b0, 16'h0000, 16'h1234, 16'h0000, 1'b0);

        // Operand push with slow ack and a stray start during BUS.
        fixed_dly = 3;
        run_seq(1'b0, 16'h8000, 16'h2000, 16'hBEEF, 1'b1);
        chk("operand_mem", mem[16'h1FFE], 16'hBEEF);

        // Reset while a 3-item pop waits in BUS.
        fixed_dly = 0;
        hold_ack = 1'b1;
        i_dir_pop = 1'b1;
        i_mask = 16'h0083;
        i_sp_in = 16'h3000;
        i_start = 1'b1;
        @(posedge i_clk);
        #1;
        i_start = 1'b0;
        for (int c = 0; c < 10 && !o_mem_req; c++) begin
            @(posedge i_clk);
            #1;
        end
        chk("rst_bus_entered", o_mem_req, 1);
        i_reset = 1'b1;
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
        hold_ack = 1'b0;
        @(negedge i_clk);
        chk("rst_req_drop", o_mem_req, 0);
        chk("rst_busy", o_busy, 0);
        bad = 1'b0;
        repeat (4) begin
            @(negedge i_clk);
            bad = bad | o_reg_we | o_sp_we | o_done | o_mem_req;
        end
        chk("rst_quiet", bad, 0);
        @(posedge i_clk);
        #1;
        run_seq(1'b1, 16'h0083, 16'h3000, 16'h0000, 1'b0);

        // Random traffic with random ack delays and stray acks.
        fixed_dly = -1;
        dly_max = 3;
        noise = 1'b1;
        for (int t = 0; t < 40; t++) begin
            rand_regs();
            run_seq(1'($urandom), 16'($urandom), 16'($urandom), 16'($urandom), 1'b0);
        end
        noise = 1'b0;

        @(posedge i_clk);
        #1;
        i_reset = 1'b1;
        @(posedge i_clk);
        @(negedge i_clk);
        chk("final_reset", {o_reg_sel, o_reg_we, o_reg_wdata, o_mem_req, o_mem_write,
            o_mem_addr, o_mem_wdata, o_sp_out, o_sp_we, o_busy, o_done}, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
